tim_apb_master: RTL and testbench

- APB initiator that drives the timer's register slave port from a simple valid/ready command interface.
- Sequences each command through APB SETUP and ACCESS phases, waits for pready, and returns read data and error status on a response channel.
- Bounds pready wait with a timeout counter, so a stuck slave cannot hang the host.
- Sits between the host/test sequencer and the timer's APB slave interface.

---
 rtl/tim_pkg.sv | 14 +
 rtl/tim_apb_master.sv | 120 ++++++++++++
 tb/tb_tim_apb_master.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/tim_pkg.sv
// tim_pkg: timer register map, APB master state encoding and default bus widths.
package tim_pkg;
   localparam int TIM_ADDR_W = 12;
   localparam int TIM_DATA_W = 32;
   localparam logic [11:0] TIM_TCR   = 12'h000;
   localparam logic [11:0] TIM_TDR0  = 12'h004;
   localparam logic [11:0] TIM_TDR1  = 12'h008;
   localparam logic [11:0] TIM_TCMP0 = 12'h00C;
   localparam logic [11:0] TIM_TCMP1 = 12'h010;
   localparam logic [11:0] TIM_TIER  = 12'h014;
   localparam logic [11:0] TIM_TISR  = 12'h018;
   localparam logic [11:0] TIM_THCSR = 12'h01C;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;
endpackage

// File: rtl/tim_apb_master.sv
// tim_apb_master: valid/ready command to APB initiator with a bounded pready wait.
module tim_apb_master
   import tim_pkg::*;
#(
   parameter int ADDR_W  = TIM_ADDR_W,
   parameter int DATA_W  = TIM_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_strb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                rsp_timeout,
   output logic                tim_psel,
   output logic                tim_penable,
   output logic                tim_pwrite,
   output logic [ADDR_W-1:0]   tim_paddr,
   output logic [DATA_W-1:0]   tim_pwdata,
   output logic [DATA_W/8-1:0] tim_pstrb,
   input  logic [DATA_W-1:0]   tim_prdata,
   input  logic                tim_pready,
   input  logic                tim_pslverr
);
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   apb_state_e          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                write_q, write_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W/8-1:0] strb_q, strb_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                to_q, to_d;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      to_d    = to_q;
      case (state_q)
         IDLE: if (cmd_valid) begin
            state_d = SETUP;
            write_d = cmd_write;
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
            strb_d  = cmd_write ? cmd_strb : '0;
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = '0;
         end
         ACCESS: if (tim_pready) begin
            state_d = RESP;
            rdata_d = write_q ? '0 : tim_prdata;
            err_d   = tim_pslverr;
            to_d    = 1'b0;
         end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b1;
            to_d    = 1'b1;
         end else begin
            // saturate so a disabled timeout never wraps the counter
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
         end
         RESP: if (rsp_ready) begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         to_q    <= to_d;
      end
   end
   assign cmd_ready   = state_q == IDLE;
   assign tim_psel    = state_q == SETUP || state_q == ACCESS;
   assign tim_penable = state_q == ACCESS;
   assign rsp_valid   = state_q == RESP;
   assign tim_pwrite  = write_q;
   assign tim_paddr   = addr_q;
   assign tim_pwdata  = wdata_q;
   assign tim_pstrb   = strb_q;
   assign rsp_rdata   = rdata_q;
   assign rsp_err     = err_q;
   assign rsp_timeout = to_q;
endmodule

// File: tb/tb_tim_apb_master.sv
// tb_tim_apb_master: table-driven check of tim_apb_master against a small timer register slave.
module tb_tim_apb_master;
   import tim_pkg::*;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [11:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        psel, penable, pwrite, pready, pslverr;
   logic [11:0] paddr;
   logic [31:0] pwdata, prdata;
   logic [3:0]  pstrb;
   int          pass = 0, total = 0;
   int          wait_n = 0, acc_cnt = 0;
   logic [31:0] mem [8];

   always #5 clk = ~clk;

   tim_apb_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(16)) dut (
      .sys_clk(clk), .sys_rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .tim_psel(psel), .tim_penable(penable), .tim_pwrite(pwrite),
      .tim_paddr(paddr), .tim_pwdata(pwdata), .tim_pstrb(pstrb),
      .tim_prdata(prdata), .tim_pready(pready), .tim_pslverr(pslverr)
   );

   // slave: registers below 0x20, error above; pready after wait_n stalled ACCESS cycles
   assign pready  = psel && penable && acc_cnt >= wait_n;
   assign pslverr = pready && paddr >= 12'h020;
   assign prdata  = (paddr < 12'h020) ? mem[paddr[4:2]] : 32'h0;
   always @(posedge clk) acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) mem[i] <= (i == 3 || i == 4) ? 32'hFFFF_FFFF : 32'h0;
      end else if (psel && penable && pready && pwrite && paddr < 12'h020) begin
         for (int b = 0; b < 4; b++) if (pstrb[b]) mem[paddr[4:2]][8*b +: 8] <= pwdata[8*b +: 8];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   typedef struct {
      logic        write;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          waits;
      int          hold;
      logic [31:0] rdata;
      logic        err;
      logic        to;
      int          lat;
   } vec_t;

   task automatic run_cmd(input vec_t v);
      int   cyc, pen;
      logic bad_bus, bad_rdy, bad_hold;
      cmd_valid = 1'b1;
      cmd_write = v.write;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      cmd_strb  = v.strb;
      wait_n    = v.waits;
      rsp_ready = (v.hold == 0);
      chk("cmd_ready_idle", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      cyc = 1;
      pen = 0;
      bad_bus = 0;
      bad_rdy = 0;
      bad_hold = 0;
      while (!rsp_valid && cyc < 40) begin
         if (penable) pen++;
         if (!psel || paddr !== v.addr || pwrite !== v.write || pstrb !== (v.write ? v.strb : 4'h0)) bad_bus = 1;
         if (cmd_ready) bad_rdy = 1;
         @(negedge clk);
         cyc++;
      end
      chk("latency", cyc, v.lat);
      chk("penable_cycles", pen, v.lat - 2);
      chk("bus_stable", {31'h0, bad_bus}, 0);
      chk("cmd_ready_busy", {31'h0, bad_rdy}, 0);
      chk("rsp_rdata", rsp_rdata, v.rdata);
      chk("rsp_err_timeout", {30'h0, rsp_err, rsp_timeout}, {30'h0, v.err, v.to});
      chk("psel_in_resp", {30'h0, psel, penable}, 0);
      repeat (v.hold) begin
         @(negedge clk);
         if (!rsp_valid || rsp_rdata !== v.rdata || rsp_err !== v.err || cmd_ready || psel) bad_hold = 1;
      end
      if (v.hold != 0) chk("rsp_hold", {31'h0, bad_hold}, 0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("back_to_idle", {30'h0, rsp_valid, cmd_ready}, 32'h1);
   endtask

   vec_t vecs [12];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{1'b1, TIM_TCR,   32'h0000_0103, 4'hF, 0,   0, 32'h0,         1'b0, 1'b0, 3};
      vecs[1]  = '{1'b0, TIM_TCR,   32'h0,         4'hF, 0,   0, 32'h0000_0103, 1'b0, 1'b0, 3};
      vecs[2]  = '{1'b0, TIM_TCMP0, 32'h0,         4'hF, 0,   5, 32'hFFFF_FFFF, 1'b0, 1'b0, 3};
      vecs[3]  = '{1'b1, TIM_TDR0,  32'hAABB_CCDD, 4'h5, 0,   0, 32'h0,         1'b0, 1'b0, 3};
      vecs[4]  = '{1'b0, TIM_TDR0,  32'h0,         4'h0, 3,   0, 32'h00BB_00DD, 1'b0, 1'b0, 6};
      vecs[5]  = '{1'b1, 12'h020,   32'h1111_2222, 4'hF, 0,   0, 32'h0,         1'b1, 1'b0, 3};
      vecs[6]  = '{1'b0, 12'h024,   32'h0,         4'h0, 1,   0, 32'h0,         1'b1, 1'b0, 4};
      vecs[7]  = '{1'b1, TIM_TIER,  32'h1234_5678, 4'hF, 2,   0, 32'h0,         1'b0, 1'b0, 5};
      vecs[8]  = '{1'b0, TIM_TIER,  32'h0,         4'h0, 1,   2, 32'h1234_5678, 1'b0, 1'b0, 4};
      vecs[9]  = '{1'b0, TIM_TIER,  32'h0,         4'h0, 15,  0, 32'h1234_5678, 1'b0, 1'b0, 18};
      vecs[10] = '{1'b0, TIM_TIER,  32'h0,         4'h0, 255, 0, 32'h0,         1'b1, 1'b1, 18};
      vecs[11] = '{1'b1, TIM_TISR,  32'hDEAD_BEEF, 4'hF, 255, 1, 32'h0,         1'b1, 1'b1, 18};
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr = '0;
      cmd_wdata = '0;
      cmd_strb = '0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_cmd_ready", cmd_ready, 1);
      chk("reset_apb", {29'h0, psel, penable, pwrite}, 0);
      chk("reset_rsp", {29'h0, rsp_valid, rsp_err, rsp_timeout}, 0);
      chk("reset_rdata", rsp_rdata, 0);
      chk("reset_paddr_pstrb", {16'h0, paddr, pstrb}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 12; i++) run_cmd(vecs[i]);
      // asynchronous reset in the middle of a stalled ACCESS phase
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = TIM_TDR1;
      wait_n    = 255;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("pre_reset_access", {30'h0, psel, penable}, 32'h3);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outputs", {29'h0, psel, penable, rsp_valid}, 0);
      chk("async_reset_cmd_ready", cmd_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("after_reset_idle", {29'h0, cmd_ready, psel, rsp_valid}, 32'h4);
      run_cmd('{1'b0, TIM_TCMP1, 32'h0, 4'h0, 0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 3});
      run_cmd('{1'b0, TIM_TCR,   32'h0, 4'h0, 2, 0, 32'h0,         1'b0, 1'b0, 5});
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
